// File: rtl/ram_copy_dma.sv
// Word-copy DMA: moves LEN 32-bit words from SRC to DST over the single-port data RAM,
// one read cycle followed by one write cycle per word.
module ram_copy_dma #(
    parameter int MEM_WORDS = 64,
    parameter int LEN_W     = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [31:0]      mem_a,
    output logic             mem_we,
    output logic             mem_re,
    output logic [31:0]      mem_wd,
    input  logic [31:0]      mem_rd
);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;

    state_t           state, state_nx;
    logic [31:0]      src_ptr, dst_ptr, data_q;
    logic [LEN_W-1:0] remaining;
    logic             err_q;
    logic             misaligned, out_of_range, req_bad;
    logic [32:0]      src_end, dst_end;

    // Word-index end points carried in 33 bits so a huge address plus len cannot wrap.
    always_comb begin
        src_end      = {3'b000, src_addr[31:2]} + 33'(len);
        dst_end      = {3'b000, dst_addr[31:2]} + 33'(len);
        misaligned   = (src_addr[1:0] != 2'b00) || (dst_addr[1:0] != 2'b00);
        out_of_range = (src_end > 33'(MEM_WORDS)) || (dst_end > 33'(MEM_WORDS));
        req_bad      = misaligned || out_of_range;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (req_bad || (len == '0)) state_nx = S_DONE;
                    else                        state_nx = S_READ;
                end
            end
            S_READ:  state_nx = S_WRITE;
            S_WRITE: state_nx = (remaining == LEN_W'(1)) ? S_DONE : S_READ;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_ptr   <= '0;
            dst_ptr   <= '0;
            data_q    <= '0;
            remaining <= '0;
            err_q     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        src_ptr   <= src_addr;
                        dst_ptr   <= dst_addr;
                        remaining <= len;
                        err_q     <= req_bad;
                    end
                end
                S_READ: data_q <= mem_rd;
                S_WRITE: begin
                    src_ptr   <= src_ptr + 32'd4;
                    dst_ptr   <= dst_ptr + 32'd4;
                    remaining <= remaining - LEN_W'(1);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        busy   = 1'b0;
        done   = 1'b0;
        mem_a  = '0;
        mem_we = 1'b0;
        mem_re = 1'b0;
        mem_wd = '0;
        case (state)
            S_READ: begin
                busy   = 1'b1;
                mem_re = 1'b1;
                mem_a  = src_ptr;
            end
            S_WRITE: begin
                busy   = 1'b1;
                mem_we = 1'b1;
                mem_a  = dst_ptr;
                mem_wd = data_q;
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    assign err = err_q;

endmodule
